// File: rtl/apb_timer_pkg.sv
// ---------------------------------------------------------------------------
// apb_timer_pkg
// Shared definitions for the APB timer slave: register offsets (word index
// taken from paddr[4:2]), CTRL/STATUS bit positions and the APB phase FSM
// state type. Imported by apb_timer_slave and apb_down_counter.
// ---------------------------------------------------------------------------
package apb_timer_pkg;

    // Register word offsets (paddr[4:2])
    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_LOAD     = 3'd1;
    localparam logic [2:0] REG_COUNT    = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_SCRATCH0 = 3'd4;
    localparam logic [2:0] REG_SCRATCH1 = 3'd5;
    localparam logic [2:0] REG_SCRATCH2 = 3'd6;
    localparam logic [2:0] REG_SCRATCH3 = 3'd7;

    // CTRL bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_AUTO = 2;

    // STATUS bit positions (both write-1-to-clear)
    localparam int STS_EXP  = 0;
    localparam int STS_PERR = 1;

    // APB phase tracker. SETUP means a setup phase has been seen, so the
    // next cycle with penable is a legal access phase.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_down_counter.sv
// ---------------------------------------------------------------------------
// apb_down_counter
// Down counter with load-on-enable, auto-reload and a combinational expiry
// flag that is valid for the cycle whose closing edge performs the expiry.
//
// Ports:
//   clk          in   clock, all state on rising edge
//   rst          in   synchronous active-high reset
//   en           in   enable (CTRL.EN register value)
//   stop         in   EN is being written to 0 on this edge: hold everything
//   auto_reload  in   reload from load_val on expiry instead of stopping
//   load_val     in   reload value (LOAD register)
//   count        out  current count
//   expire       out  high in the cycle whose edge sees EN=1 and count==0
// ---------------------------------------------------------------------------
module apb_down_counter
    import apb_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;
    logic             en_p1;   // EN delayed one cycle, used to spot 0->1
    logic             start;
    logic             run;

    // The first edge after EN rises only loads; counting starts one edge
    // later, so a stale COUNT of 0 is never mistaken for an expiry.
    always_comb begin
        start  = en && !en_p1 && !stop;
        run    = en && en_p1 && !stop;
        expire = run && (count_q == '0);
    end

    // ---- stage boundary: count register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            en_p1   <= 1'b0;
        end else begin
            en_p1 <= en;
            if (start) begin
                count_q <= load_val;
            end else if (expire) begin
                // One-shot mode leaves COUNT at 0; the top clears EN.
                if (auto_reload) begin
                    count_q <= load_val;
                end
            end else if (run) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign count = count_q;

endmodule

// File: rtl/apb_timer_slave.sv
// ---------------------------------------------------------------------------
// apb_timer_slave
// APB slave with a programmable down-counting timer and four scratch
// registers. Zero wait states, combinational read data, registered irq.
//
// Register map (paddr[4:2]):
//   0 CTRL    RW  [0] EN, [1] IE, [2] AUTO
//   1 LOAD    RW  CNT_W bits, upper bits read 0
//   2 COUNT   RO  CNT_W bits, upper bits read 0
//   3 STATUS  W1C [0] EXP (timer expired), [1] PERR (access without setup)
//   4-7 SCRATCH0-3 RW
//
// Parameters:
//   CNT_W        counter/LOAD width, legal range 8..32
//   SCRATCH_RST  reset value of the scratch registers
//
// Ports:
//   hclk     in   clock, all state on rising edge
//   hreset   in   synchronous active-high reset
//   psel     in   this slave's select line
//   penable  in   APB access phase
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address, only [4:2] decoded
//   pwdata   in   write data
//   prdata   out  read data (combinational, 0 when not reading)
//   irq      out  registered EXP & IE
// ---------------------------------------------------------------------------
module apb_timer_slave
    import apb_timer_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        irq
);

    apb_state_e       state_q;
    apb_state_e       state_d;
    logic             acc_ok;     // legal access phase this cycle
    logic             prot_err;   // access phase without a preceding setup
    logic             wr_en;
    logic             ctrl_wr;
    logic             sts_wr;
    logic             stop;
    logic [2:0]       reg_idx;

    logic             ctrl_en;
    logic             ctrl_ie;
    logic             ctrl_auto;
    logic [CNT_W-1:0] load_q;
    logic             sts_exp;
    logic             sts_perr;
    logic [31:0]      scratch_q [4];
    logic             irq_q;

    logic [CNT_W-1:0] count;
    logic             expire;
    logic [31:0]      rd_data;

    // Address bits outside [4:2] are deliberately ignored.
    logic             unused_paddr;
    assign unused_paddr = ^{paddr[31:5], paddr[1:0]};

    assign reg_idx = paddr[4:2];

    // ---- stage boundary: APB phase FSM state register ----
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // During the access phase the state register still reads SETUP; it
    // moves to ACCESS on the edge that completes the transfer.
    always_comb begin
        state_d  = state_q;
        acc_ok   = 1'b0;
        prot_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (psel && penable) begin
                    prot_err = 1'b1;
                end else if (psel) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (psel && penable) begin
                    acc_ok  = 1'b1;
                    state_d = ST_ACCESS;
                end else if (!psel) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (psel && !penable) begin
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_en   = acc_ok && pwrite;
        ctrl_wr = wr_en && (reg_idx == REG_CTRL);
        sts_wr  = wr_en && (reg_idx == REG_STATUS);
        // Clearing EN freezes COUNT on the very edge of the write.
        stop    = ctrl_wr && !pwdata[CTRL_EN];
    end

    apb_down_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk         (hclk),
        .rst         (hreset),
        .en          (ctrl_en),
        .stop        (stop),
        .auto_reload (ctrl_auto),
        .load_val    (load_q),
        .count       (count),
        .expire      (expire)
    );

    // ---- stage boundary: register bank and irq ----
    always_ff @(posedge hclk) begin
        if (hreset) begin
            ctrl_en   <= 1'b0;
            ctrl_ie   <= 1'b0;
            ctrl_auto <= 1'b0;
            load_q    <= '0;
            sts_exp   <= 1'b0;
            sts_perr  <= 1'b0;
            irq_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                scratch_q[i] <= SCRATCH_RST;
            end
        end else begin
            // One-shot expiry drops EN; a CTRL write on the same edge wins.
            if (expire && !ctrl_auto) begin
                ctrl_en <= 1'b0;
            end
            if (wr_en) begin
                case (reg_idx)
                    REG_CTRL: begin
                        ctrl_en   <= pwdata[CTRL_EN];
                        ctrl_ie   <= pwdata[CTRL_IE];
                        ctrl_auto <= pwdata[CTRL_AUTO];
                    end
                    REG_LOAD: begin
                        load_q <= pwdata[CNT_W-1:0];
                    end
                    REG_SCRATCH0, REG_SCRATCH1, REG_SCRATCH2, REG_SCRATCH3: begin
                        scratch_q[reg_idx[1:0]] <= pwdata;
                    end
                    default: begin
                        // COUNT is read-only; STATUS is handled below.
                    end
                endcase
            end
            // New events take priority over a simultaneous W1C.
            sts_exp  <= (sts_exp  && !(sts_wr && pwdata[STS_EXP]))  || expire;
            sts_perr <= (sts_perr && !(sts_wr && pwdata[STS_PERR])) || prot_err;
            irq_q    <= sts_exp && ctrl_ie;
        end
    end

    assign irq = irq_q;

    // Read mux; an access phase arriving without setup returns 0.
    always_comb begin
        rd_data = '0;
        case (reg_idx)
            REG_CTRL: begin
                rd_data[CTRL_EN]   = ctrl_en;
                rd_data[CTRL_IE]   = ctrl_ie;
                rd_data[CTRL_AUTO] = ctrl_auto;
            end
            REG_LOAD: begin
                rd_data = 32'(load_q);
            end
            REG_COUNT: begin
                rd_data = 32'(count);
            end
            REG_STATUS: begin
                rd_data[STS_EXP]  = sts_exp;
                rd_data[STS_PERR] = sts_perr;
            end
            default: begin
                rd_data = scratch_q[reg_idx[1:0]];
            end
        endcase
        if (psel && !pwrite && !((state_q == ST_IDLE) && penable)) begin
            prdata = rd_data;
        end else begin
            prdata = '0;
        end
    end

endmodule

// File: tb/tb_apb_timer_slave.sv
module tb_apb_timer_slave;

    localparam int          CNT_W    = 16;
    localparam logic [31:0] SCR_RST  = 32'h5A5A_1234;
    localparam logic [31:0] CNT_MASK = 32'h0000_FFFF;
    localparam logic [2:0]  A_CTRL   = 3'd0;
    localparam logic [2:0]  A_LOAD   = 3'd1;
    localparam logic [2:0]  A_COUNT  = 3'd2;
    localparam logic [2:0]  A_STATUS = 3'd3;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        irq;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [31:0] scr_m [4];

    apb_timer_slave #(
        .CNT_W       (CNT_W),
        .SCRATCH_RST (SCR_RST)
    ) dut (
        .hclk    (hclk),
        .hreset  (hreset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .irq     (irq)
    );

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    // Reference timing model, from the timer rules:
    // edge k after the EN write: k=1 loads LOAD, then one decrement per edge,
    // expiry (and reload in auto mode) on the edge after COUNT reaches 0.
    function automatic logic [31:0] auto_count(input int l, input int k);
        return 32'(l - ((k - 1) % (l + 1)));
    endfunction

    function automatic logic [31:0] oneshot_count(input int l, input int k);
        return (k - 1 >= l) ? 32'd0 : 32'(l - (k - 1));
    endfunction

    function automatic logic [31:0] addr_of(input logic [2:0] idx);
        logic [31:0] a;
        a = $urandom();
        a[4:2] = idx;
        return a;
    endfunction

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [2:0] idx, input logic [31:0] data);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = addr_of(idx);
        pwdata  = data;
        tick();
        penable = 1'b1;
        tick();
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [2:0] idx, output logic [31:0] data);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = addr_of(idx);
        tick();
        penable = 1'b1;
        #1;
        data = prdata;
        tick();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] v;
        apb_read(idx, v);
        check(tag, v, exp);
    endtask

    // Observe a register mid-cycle by holding a setup phase (no side effects).
    task automatic peek(input logic [2:0] idx, output logic [31:0] data);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = addr_of(idx);
        #1;
        data = prdata;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] d;
        int          l;
        int          e0;
        int          nk;
        int          kw;

        hreset  = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        for (int i = 0; i < 4; i++) scr_m[i] = SCR_RST;

        // Reset state
        repeat (3) tick();
        check("rst_prdata_idle", prdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        hreset = 1'b0;
        tick();
        read_check("rst_ctrl",   A_CTRL,   32'd0);
        read_check("rst_load",   A_LOAD,   32'd0);
        read_check("rst_count",  A_COUNT,  32'd0);
        read_check("rst_status", A_STATUS, 32'd0);
        for (int i = 0; i < 4; i++) read_check("rst_scratch", 3'(4 + i), scr_m[i]);

        // Scratch registers: directed then random writes
        apb_write(3'd6, 32'hDEAD_BEEF);
        scr_m[2] = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) read_check("scratch_deadbeef", 3'(4 + i), scr_m[i]);
        for (int n = 0; n < 10; n++) begin
            int idx;
            idx = int'($urandom_range(0, 3));
            d   = $urandom();
            apb_write(3'(4 + idx), d);
            scr_m[idx] = d;
        end
        for (int i = 0; i < 4; i++) read_check("scratch_random", 3'(4 + i), scr_m[i]);

        // CTRL/LOAD masking, COUNT read-only
        d = $urandom() & 32'hFFFF_FFFE;
        apb_write(A_CTRL, d);
        read_check("ctrl_mask", A_CTRL, d & 32'h6);
        apb_write(A_CTRL, 32'd0);
        d = $urandom();
        apb_write(A_LOAD, d);
        read_check("load_mask", A_LOAD, d & CNT_MASK);
        apb_write(A_COUNT, $urandom());
        read_check("count_ro", A_COUNT, 32'd0);

        // Auto-reload periods, irq timing and freeze on EN=0
        for (int it = 0; it < 3; it++) begin
            l = (it == 0) ? 3 : int'($urandom_range(0, 6));
            apb_write(A_STATUS, 32'd3);
            apb_write(A_LOAD, 32'(l));
            apb_write(A_CTRL, 32'd7);
            e0 = cyc;
            nk = 3 * (l + 1) + l + 1;
            for (int k = 1; k <= nk; k++) begin
                tick();
                peek(A_COUNT, v);
                check("auto_count", v, auto_count(l, k));
                peek(A_STATUS, v);
                check("auto_exp", {31'd0, v[0]}, (k >= l + 2) ? 32'd1 : 32'd0);
                check("auto_irq", {31'd0, irq}, (k >= l + 3) ? 32'd1 : 32'd0);
            end
            apb_write(A_CTRL, 32'd0);
            kw = cyc - e0;
            read_check("freeze_count", A_COUNT, auto_count(l, kw - 1));
            tick();
            read_check("freeze_hold", A_COUNT, auto_count(l, kw - 1));
        end

        // W1C racing an expiry, then W1C on a quiet edge
        apb_write(A_STATUS, 32'd3);
        apb_write(A_LOAD, 32'd3);
        apb_write(A_CTRL, 32'd7);
        e0 = cyc;
        while (cyc < e0 + 7) tick();
        apb_write(A_STATUS, 32'd1);          // commits on expiry edge e0+9
        peek(A_STATUS, v);
        check("w1c_on_expiry_exp", {31'd0, v[0]}, 32'd1);
        apb_write(A_STATUS, 32'd1);          // commits on e0+11, no expiry
        peek(A_STATUS, v);
        check("w1c_quiet_exp", {31'd0, v[0]}, 32'd0);
        check("w1c_quiet_irq_still", {31'd0, irq}, 32'd1);
        tick();
        check("w1c_quiet_irq_drop", {31'd0, irq}, 32'd0);
        peek(A_STATUS, v);
        check("w1c_exp_stays_low", {31'd0, v[0]}, 32'd0);
        tick();
        peek(A_STATUS, v);
        check("w1c_next_expiry", {31'd0, v[0]}, 32'd1);
        apb_write(A_CTRL, 32'd0);

        // One-shot mode
        for (int it = 0; it < 2; it++) begin
            l = (it == 0) ? 2 : int'($urandom_range(0, 5));
            apb_write(A_STATUS, 32'd3);
            apb_write(A_LOAD, 32'(l));
            apb_write(A_CTRL, 32'd3);
            e0 = cyc;
            for (int k = 1; k <= l + 5; k++) begin
                tick();
                peek(A_COUNT, v);
                check("oneshot_count", v, oneshot_count(l, k));
                peek(A_STATUS, v);
                check("oneshot_exp", {31'd0, v[0]}, (k >= l + 2) ? 32'd1 : 32'd0);
            end
            read_check("oneshot_ctrl", A_CTRL, 32'd2);
            read_check("oneshot_count_hold", A_COUNT, 32'd0);
        end

        // Access phase without setup: PERR, no write, prdata 0
        apb_write(A_STATUS, 32'd3);
        tick();
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = addr_of(3'd6);
        #1;
        check("perr_read_prdata", prdata, 32'd0);
        tick();
        pwrite = 1'b1;
        paddr  = addr_of(3'd4);
        pwdata = ~scr_m[0];
        tick();
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        tick();
        read_check("perr_status", A_STATUS, 32'd2);
        read_check("perr_scratch0", 3'd4, scr_m[0]);
        apb_write(A_STATUS, 32'd2);
        read_check("perr_w1c", A_STATUS, 32'd0);

        // Reset in the access phase of a write, while the timer runs
        apb_write(A_LOAD, 32'd5);
        apb_write(A_CTRL, 32'd7);
        repeat (3) tick();
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = addr_of(3'd5);
        pwdata  = ~SCR_RST;
        tick();
        penable = 1'b1;
        hreset  = 1'b1;
        tick();
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        #1;
        check("rst_mid_prdata", prdata, 32'd0);
        tick();
        hreset = 1'b0;
        for (int i = 0; i < 4; i++) scr_m[i] = SCR_RST;
        check("rst_mid_irq", {31'd0, irq}, 32'd0);
        read_check("rst_mid_ctrl",   A_CTRL,   32'd0);
        read_check("rst_mid_load",   A_LOAD,   32'd0);
        read_check("rst_mid_count",  A_COUNT,  32'd0);
        read_check("rst_mid_status", A_STATUS, 32'd0);
        for (int i = 0; i < 4; i++) read_check("rst_mid_scratch", 3'(4 + i), scr_m[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_timer_slave.md
APB_TIMER_SLAVE -- requirements
Module: apb_timer_slave

Interface
REQ-001 SHALL have parameter CNT_W, default 32: counter/LOAD width, legal range 8..32; unused upper register bits read 0.
REQ-002 SHALL have parameter SCRATCH_RST, default 32'h0000_0000: reset value of the scratch registers.
REQ-003 hclk  input  1  single clock, all state on rising edge.
REQ-004 hreset  input  1  synchronous, active-high reset.
REQ-005 psel  input  1  one bit of the bridge psel[2:0] bus; this slave is selected.
REQ-006 penable  input  1  APB access phase.
REQ-007 pwrite  input  1  1 = write, 0 = read.
REQ-008 paddr  input  32  byte address; only paddr[4:2] decoded.
REQ-009 pwdata  input  32  write data.
REQ-010 prdata  output  32  read data.
REQ-011 irq  output  1  timer interrupt, registered.

Function
REQ-012 Register map (paddr[4:2]): 0 CTRL RW; 1 LOAD RW; 2 COUNT RO; 3 STATUS; 4-7 SCRATCH0-3 RW.
- CTRL bits: [0] EN, [1] IE, [2] AUTO; other bits read 0.
- STATUS bits: [0] EXP, [1] PERR; both W1C.
REQ-013 Phase FSM states IDLE, SETUP, ACCESS:
- IDLE -> SETUP on psel & !penable.
- SETUP -> ACCESS on psel & penable; SETUP -> IDLE on !psel.
- ACCESS -> SETUP on psel & !penable, else IDLE.
REQ-014 A write SHALL commit on the clock edge ending ACCESS (psel & penable & pwrite); writes to COUNT SHALL be ignored.
REQ-015 prdata SHALL be combinational: the selected register when psel & !pwrite, else 0; zero wait states.
REQ-016 psel & penable seen in IDLE SHALL set PERR, and that access SHALL be ignored (no write, prdata 0).
REQ-017 Writing CTRL.EN 0->1 SHALL load COUNT=LOAD on the next edge; decrement begins on the following edge.
REQ-018 While EN=1 and COUNT!=0, COUNT SHALL decrement by 1 per cycle.
REQ-019 On the edge where EN=1 and COUNT==0: EXP SHALL set; if AUTO=1, COUNT=LOAD; otherwise EN clears and COUNT stays 0.
REQ-020 Period with AUTO=1 SHALL be LOAD+1 cycles; LOAD=0 SHALL expire every cycle.
REQ-021 A LOAD write while running SHALL NOT disturb COUNT; it takes effect at the next reload or enable.
REQ-022 Writing EN=0 SHALL freeze COUNT at its current value on that edge.
REQ-023 Simultaneous W1C of EXP and a new expiry SHALL leave EXP=1.
REQ-024 irq SHALL register EXP & IE one cycle after EXP/IE change.

Reset
REQ-025 hreset=1 at an edge SHALL force: FSM IDLE, CTRL=0, LOAD=0, COUNT=0, STATUS=0, SCRATCH0-3=SCRATCH_RST, irq=0.
REQ-026 Reset asserted mid-access or mid-count SHALL abort the access with no register write.
REQ-027 prdata SHALL be 0 while psel=0, including during reset.

Structure
REQ-028 A shared package apb_timer_pkg SHALL hold: register offset constants, CTRL/STATUS bit indices, and the FSM state enum.
REQ-029 Exactly one sub-module SHALL exist: apb_down_counter (load, enable, auto-reload, expiry pulse); decode and the register bank stay in the top.

Verification
REQ-030 Reset, then read all 8 offsets -> CTRL=0, LOAD=0, COUNT=0, STATUS=0, SCRATCH=SCRATCH_RST.
REQ-031 Write SCRATCH2=32'hDEAD_BEEF, then read it -> prdata 32'hDEAD_BEEF during ACCESS; other scratch registers unchanged.
REQ-032 LOAD=3, CTRL=3'b111 -> EXP rises 5 cycles after the CTRL write edge, then every 4 cycles; irq follows one cycle later.
REQ-033 LOAD=2, CTRL=3'b011 (one-shot) -> one expiry; EN reads 0 afterwards; COUNT holds 0.
REQ-034 W1C STATUS=1 timed on the same edge as an expiry -> EXP reads 1; W1C on a non-expiry edge -> EXP reads 0 and irq drops next cycle.
REQ-035 penable=1 with psel=1 from IDLE, pwrite=1 to SCRATCH0 -> STATUS.PERR=1 and SCRATCH0 unchanged; hreset during ACCESS -> no write committed.
